source_inlet_dispenser: RTL and testbench

Upstream metering stage for the synthetic assay netlists: the clocked controller that feeds the `Source` inlet. It accepts dispense commands over a valid/ready handshake and primes the inlet. It then drives a three-valve peristaltic pump through a fixed six-phase pattern for a commanded number of strokes, and seals the channel before reporting completion. All downstream chambers, heaters, filters and mixers see fluid only through the valves this block drives.

---
 rtl/source_inlet_pkg.sv | 36 +++
 rtl/peristaltic_phase_seq.sv | 72 +++++++
 rtl/source_inlet_dispenser.sv | 202 ++++++++++++++++++++
 tb/tb_source_inlet_dispenser.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/source_inlet_pkg.sv
// Shared definitions for the source inlet dispenser: controller state
// encoding, the peristaltic closed-mask pattern and the sealed mask.
package source_inlet_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PRIME,
        ST_PUMP,
        ST_SETTLE,
        ST_DONE
    } state_e;

    localparam int NUM_PHASES = 6;

    // Bit set = valve closed.
    localparam logic [2:0] SEALED_MASK = 3'b111;

    // Closed-mask per pump phase; one stroke walks all six entries.
    localparam logic [2:0] PHASE_MASK [NUM_PHASES] = '{
        3'b100, 3'b110, 3'b010, 3'b011, 3'b001, 3'b101
    };

    // Phase index to mask; out-of-range indices fall back to sealed.
    function automatic logic [2:0] phase_mask(input logic [2:0] idx);
        case (idx)
            3'd0:    return PHASE_MASK[0];
            3'd1:    return PHASE_MASK[1];
            3'd2:    return PHASE_MASK[2];
            3'd3:    return PHASE_MASK[3];
            3'd4:    return PHASE_MASK[4];
            3'd5:    return PHASE_MASK[5];
            default: return SEALED_MASK;
        endcase
    endfunction

endpackage

// File: rtl/peristaltic_phase_seq.sv
// Peristaltic phase sequencer: walks the six-phase closed-mask ring, holding
// each phase for phase_len cycles (0 behaves as 1).
// Ports:
//   clk_i, rst_n_i  : clock, async active-low reset
//   enable_i        : pumping in the coming cycle (drives the registered mask)
//   restart_i       : pumping starts in the coming cycle; begin at phase 0
//   phase_len_i     : dwell per phase in cycles
//   valve_pump_o    : registered closed-mask, sealed when not enabled
//   stroke_tick_o   : current cycle is the last cycle of phase 5
module peristaltic_phase_seq
    import source_inlet_pkg::*;
#(
    parameter int PHASE_W = 12
) (
    input  logic               clk_i,
    input  logic               rst_n_i,
    input  logic               enable_i,
    input  logic               restart_i,
    input  logic [PHASE_W-1:0] phase_len_i,
    output logic [2:0]         valve_pump_o,
    output logic               stroke_tick_o
);

    logic [2:0]         phase_q, phase_d;
    logic [PHASE_W-1:0] timer_q, timer_d;
    logic               run_q, run_d;
    logic [2:0]         mask_q, mask_d;
    logic [PHASE_W-1:0] reload;

    // Down-counter reload; a zero length saturates to a one-cycle dwell.
    assign reload = (phase_len_i == '0) ? '0 : phase_len_i - PHASE_W'(1);

    assign stroke_tick_o = run_q && (timer_q == '0) && (phase_q == 3'd5);
    assign valve_pump_o  = mask_q;

    always_comb begin
        phase_d = phase_q;
        timer_d = timer_q;
        mask_d  = mask_q;
        run_d   = enable_i;
        if (!enable_i) begin
            phase_d = '0;
            timer_d = '0;
            mask_d  = SEALED_MASK;
        end else if (restart_i || !run_q) begin
            phase_d = '0;
            timer_d = reload;
            mask_d  = phase_mask(3'd0);
        end else if (timer_q == '0) begin
            phase_d = (phase_q == 3'd5) ? 3'd0 : phase_q + 3'd1;
            timer_d = reload;
            mask_d  = phase_mask(phase_d);
        end else begin
            timer_d = timer_q - PHASE_W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            phase_q <= '0;
            timer_q <= '0;
            run_q   <= 1'b0;
            mask_q  <= SEALED_MASK;
        end else begin
            phase_q <= phase_d;
            timer_q <= timer_d;
            run_q   <= run_d;
            mask_q  <= mask_d;
        end
    end

endmodule

// File: rtl/source_inlet_dispenser.sv
// Source inlet dispenser: accepts a dispense command, primes the inlet, runs
// the peristaltic pump for the commanded strokes, seals and settles, then
// pulses done with status flags.
// Ports:
//   clk, rst_n                 : clock, async active-low reset
//   cmd_valid/cmd_ready        : command handshake (ready only in IDLE)
//   cmd_strokes, cmd_phase_len : stroke count and per-phase dwell
//   abort                      : level; seals and ends the active command
//   valve_inlet, valve_pump    : valve drives (pump mask: 1 = closed)
//   busy, done, aborted, err_zero, strokes_done : status
//
// state  | meaning
// IDLE   | sealed, waiting for a command
// PRIME  | inlet open, pump sealed, PRIME_CYCLES cycles
// PUMP   | inlet open, six-phase pattern per stroke
// SETTLE | all sealed, SETTLE_CYCLES cycles
// DONE   | one-cycle completion pulse with flags
module source_inlet_dispenser
    import source_inlet_pkg::*;
#(
    parameter int STROKE_W      = 16,
    parameter int PHASE_W       = 12,
    parameter int PRIME_CYCLES  = 64,
    parameter int SETTLE_CYCLES = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic [STROKE_W-1:0] cmd_strokes,
    input  logic [PHASE_W-1:0]  cmd_phase_len,
    input  logic                abort,
    output logic                valve_inlet,
    output logic [2:0]          valve_pump,
    output logic                busy,
    output logic                done,
    output logic                aborted,
    output logic                err_zero,
    output logic [STROKE_W-1:0] strokes_done
);

    localparam int TMR_MAX = (PRIME_CYCLES > SETTLE_CYCLES) ? PRIME_CYCLES : SETTLE_CYCLES;
    localparam int TMR_W   = $clog2(TMR_MAX + 1);
    localparam logic [TMR_W-1:0] PRIME_LOAD  = TMR_W'(PRIME_CYCLES - 1);
    localparam logic [TMR_W-1:0] SETTLE_LOAD = TMR_W'(SETTLE_CYCLES - 1);

    state_e              state_q, state_d;
    logic [TMR_W-1:0]    tmr_q, tmr_d;
    logic [STROKE_W-1:0] strokes_q, strokes_d;
    logic [PHASE_W-1:0]  len_q, len_d;
    logic [STROKE_W-1:0] sd_q, sd_d;
    logic                abort_seen_q, abort_seen_d;
    logic                zero_q, zero_d;
    logic                ready_q, busy_q, done_q, aborted_q, err_zero_q, inlet_q;
    logic                ready_d, busy_d, done_d, aborted_d, err_zero_d, inlet_d;

    logic                accept;
    logic                stroke_tick;
    logic                seq_enable;
    logic                seq_restart;
    logic [STROKE_W-1:0] sd_inc;

    assign accept = cmd_valid && ready_q;
    assign sd_inc = sd_q + STROKE_W'(1);

    always_comb begin
        state_d      = state_q;
        tmr_d        = tmr_q;
        strokes_d    = strokes_q;
        len_d        = len_q;
        sd_d         = sd_q;
        abort_seen_d = abort_seen_q;
        zero_d       = zero_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    strokes_d    = cmd_strokes;
                    len_d        = cmd_phase_len;
                    sd_d         = '0;
                    abort_seen_d = 1'b0;
                    zero_d       = (cmd_strokes == '0);
                    if (cmd_strokes == '0) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_PRIME;
                        tmr_d   = PRIME_LOAD;
                    end
                end
            end
            ST_PRIME: begin
                if (abort) begin
                    state_d      = ST_SETTLE;
                    tmr_d        = SETTLE_LOAD;
                    abort_seen_d = 1'b1;
                end else if (tmr_q == '0) begin
                    state_d = ST_PUMP;
                end else begin
                    tmr_d = tmr_q - TMR_W'(1);
                end
            end
            ST_PUMP: begin
                // Abort outranks a stroke completing on the same edge, so the
                // count freezes at the strokes finished before the abort.
                if (abort) begin
                    state_d      = ST_SETTLE;
                    tmr_d        = SETTLE_LOAD;
                    abort_seen_d = 1'b1;
                end else if (stroke_tick) begin
                    sd_d = sd_inc;
                    if (sd_inc == strokes_q) begin
                        state_d = ST_SETTLE;
                        tmr_d   = SETTLE_LOAD;
                    end
                end
            end
            ST_SETTLE: begin
                // Abort here only marks the outcome; the settle runs its course.
                if (abort) begin
                    abort_seen_d = 1'b1;
                end
                if (tmr_q == '0) begin
                    state_d = ST_DONE;
                end else begin
                    tmr_d = tmr_q - TMR_W'(1);
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Outputs are registered from the next state so they change on the edge
    // that enters each state.
    always_comb begin
        ready_d    = (state_d == ST_IDLE);
        busy_d     = (state_d != ST_IDLE);
        done_d     = (state_d == ST_DONE);
        aborted_d  = done_d && abort_seen_d;
        err_zero_d = done_d && zero_d;
        inlet_d    = (state_d == ST_PRIME) || (state_d == ST_PUMP);
    end

    assign seq_enable  = (state_d == ST_PUMP);
    assign seq_restart = (state_d == ST_PUMP) && (state_q != ST_PUMP);

    peristaltic_phase_seq #(
        .PHASE_W (PHASE_W)
    ) u_phase_seq (
        .clk_i         (clk),
        .rst_n_i       (rst_n),
        .enable_i      (seq_enable),
        .restart_i     (seq_restart),
        .phase_len_i   (len_q),
        .valve_pump_o  (valve_pump),
        .stroke_tick_o (stroke_tick)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            tmr_q        <= '0;
            strokes_q    <= '0;
            len_q        <= '0;
            sd_q         <= '0;
            abort_seen_q <= 1'b0;
            zero_q       <= 1'b0;
            ready_q      <= 1'b1;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            aborted_q    <= 1'b0;
            err_zero_q   <= 1'b0;
            inlet_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            tmr_q        <= tmr_d;
            strokes_q    <= strokes_d;
            len_q        <= len_d;
            sd_q         <= sd_d;
            abort_seen_q <= abort_seen_d;
            zero_q       <= zero_d;
            ready_q      <= ready_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            aborted_q    <= aborted_d;
            err_zero_q   <= err_zero_d;
            inlet_q      <= inlet_d;
        end
    end

    assign cmd_ready    = ready_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign aborted      = aborted_q;
    assign err_zero     = err_zero_q;
    assign valve_inlet  = inlet_q;
    assign strokes_done = sd_q;

endmodule

// File: tb/tb_source_inlet_dispenser.sv
// Bench for source_inlet_dispenser with short prime/settle times. Expected
// per-cycle outputs come from a timeline model: cycle t counts from the
// accept edge, and each region's extent is computed arithmetically.
module tb_source_inlet_dispenser;

    localparam int PC = 4;
    localparam int SC = 2;
    localparam int SW = 16;
    localparam int PW = 12;

    logic          clk;
    logic          rst_n;
    logic          cmd_valid;
    logic          cmd_ready;
    logic [SW-1:0] cmd_strokes;
    logic [PW-1:0] cmd_phase_len;
    logic          abort;
    logic          valve_inlet;
    logic [2:0]    valve_pump;
    logic          busy;
    logic          done;
    logic          aborted;
    logic          err_zero;
    logic [SW-1:0] strokes_done;

    int n_cmp = 0;
    int n_bad = 0;
    int mask_tab [6] = '{4, 6, 2, 3, 1, 5};

    source_inlet_dispenser #(
        .STROKE_W      (SW),
        .PHASE_W       (PW),
        .PRIME_CYCLES  (PC),
        .SETTLE_CYCLES (SC)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .cmd_valid     (cmd_valid),
        .cmd_ready     (cmd_ready),
        .cmd_strokes   (cmd_strokes),
        .cmd_phase_len (cmd_phase_len),
        .abort         (abort),
        .valve_inlet   (valve_inlet),
        .valve_pump    (valve_pump),
        .busy          (busy),
        .done          (done),
        .aborted       (aborted),
        .err_zero      (err_zero),
        .strokes_done  (strokes_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Last cycle of the active pumping/priming window (abort cycle if it
    // lands in prime or pump), counted from the accept edge.
    function automatic int pump_end(input int n, input int l, input int a);
        int le, nat;
        le  = (l == 0) ? 1 : l;
        nat = PC + 6 * n * le;
        return (a >= 1 && a <= nat) ? a : nat;
    endfunction

    function automatic int done_cycle(input int n, input int l, input int a);
        if (n == 0) return 1;
        return pump_end(n, l, a) + SC + 1;
    endfunction

    task automatic model(input int n, input int l, input int a, input int t,
                         output int e_in, output int e_pump, output int e_sd,
                         output int e_done, output int e_ab, output int e_ez,
                         output int e_busy);
        int le, nat, pe, td, sd_fin, ab;
        le = (l == 0) ? 1 : l;
        e_in = 0; e_pump = 7; e_sd = 0; e_done = 0; e_ab = 0; e_ez = 0;
        if (n == 0) begin
            e_done = (t == 1);
            e_ez   = (t == 1);
            e_busy = (t <= 1);
            return;
        end
        nat = PC + 6 * n * le;
        pe  = pump_end(n, l, a);
        td  = pe + SC + 1;
        if (a >= 1 && a <= nat) begin
            ab     = 1;
            sd_fin = (a - 1 >= PC) ? (a - 1 - PC) / (6 * le) : 0;
        end else begin
            ab     = (a > pe && a <= pe + SC) ? 1 : 0;
            sd_fin = n;
        end
        e_busy = (t <= td);
        if (t <= pe) begin
            e_in = 1;
            if (t > PC) begin
                e_pump = mask_tab[((t - PC - 1) / le) % 6];
                e_sd   = (t - 1 - PC) / (6 * le);
            end
        end else begin
            e_sd = sd_fin;
            if (t == td) begin
                e_done = 1;
                e_ab   = ab;
            end
        end
    endtask

    task automatic check_cycle(input int n, input int l, input int a, input int t);
        int e_in, e_pump, e_sd, e_done, e_ab, e_ez, e_busy;
        model(n, l, a, t, e_in, e_pump, e_sd, e_done, e_ab, e_ez, e_busy);
        chk($sformatf("t%0d valve_inlet", t),  32'(valve_inlet),  32'(e_in));
        chk($sformatf("t%0d valve_pump", t),   32'(valve_pump),   32'(e_pump));
        chk($sformatf("t%0d strokes_done", t), 32'(strokes_done), 32'(e_sd));
        chk($sformatf("t%0d done", t),         32'(done),         32'(e_done));
        chk($sformatf("t%0d aborted", t),      32'(aborted),      32'(e_ab));
        chk($sformatf("t%0d err_zero", t),     32'(err_zero),     32'(e_ez));
        chk($sformatf("t%0d busy", t),         32'(busy),         32'(e_busy));
        chk($sformatf("t%0d cmd_ready", t),    32'(cmd_ready),    32'(e_busy == 0));
    endtask

    // Issue one command (accepted at the next edge), pulse abort during cycle
    // a (0 = none), and check every cycle through the return to idle.
    task automatic run_cmd(input int n, input int l, input int a);
        int td;
        @(negedge clk);
        chk("ready_before_cmd", 32'(cmd_ready), 32'd1);
        cmd_valid     = 1'b1;
        cmd_strokes   = SW'(n);
        cmd_phase_len = PW'(l);
        @(posedge clk);
        #1;
        cmd_valid     = 1'b0;
        cmd_strokes   = SW'($urandom);
        cmd_phase_len = PW'($urandom);
        td = done_cycle(n, l, a);
        for (int t = 1; t <= td + 1; t++) begin
            abort = (t == a);
            @(negedge clk);
            check_cycle(n, l, a, t);
            @(posedge clk);
            #1;
        end
        abort = 1'b0;
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, " valve_inlet"},  32'(valve_inlet),  32'd0);
        chk({tag, " valve_pump"},   32'(valve_pump),   32'd7);
        chk({tag, " busy"},         32'(busy),         32'd0);
        chk({tag, " cmd_ready"},    32'(cmd_ready),    32'd1);
        chk({tag, " done"},         32'(done),         32'd0);
        chk({tag, " aborted"},      32'(aborted),      32'd0);
        chk({tag, " err_zero"},     32'(err_zero),     32'd0);
        chk({tag, " strokes_done"}, 32'(strokes_done), 32'd0);
    endtask

    initial begin
        int n, l, a, nat, seen;
        rst_n         = 1'b1;
        cmd_valid     = 1'b0;
        cmd_strokes   = '0;
        cmd_phase_len = '0;
        abort         = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_values("reset");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Directed scenarios with known completion cycles.
        chk("done_cycle_2x3", 32'(done_cycle(2, 3, 0)), 32'd43);
        run_cmd(2, 3, 0);
        run_cmd(0, 5, 0);
        chk("done_cycle_1x0", 32'(done_cycle(1, 0, 0)), 32'd13);
        run_cmd(1, 0, 0);
        chk("done_cycle_abort", 32'(done_cycle(5, 2, 20)), 32'd23);
        run_cmd(5, 2, 20);
        run_cmd(2, 1, 2);
        run_cmd(1, 2, 19);

        // Randomized commands, some with an abort pulse in a random cycle.
        for (int i = 0; i < 12; i++) begin
            n   = $urandom_range(0, 3);
            l   = $urandom_range(0, 3);
            nat = PC + 6 * n * ((l == 0) ? 1 : l);
            a   = ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(1, nat + SC + 2);
            run_cmd(n, l, a);
        end

        // cmd_valid held through a busy period: one accept, next accepted
        // right after done.
        @(negedge clk);
        cmd_valid     = 1'b1;
        cmd_strokes   = SW'(1);
        cmd_phase_len = PW'(1);
        @(posedge clk);
        #1;
        for (int t = 1; t <= 13; t++) begin
            @(negedge clk);
            check_cycle(1, 1, 0, t);
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        chk("held_ready_after_done", 32'(cmd_ready), 32'd1);
        chk("held_idle_after_done", 32'(busy), 32'd0);
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        @(negedge clk);
        chk("held_second_busy", 32'(busy), 32'd1);
        chk("held_second_inlet", 32'(valve_inlet), 32'd1);
        chk("held_second_sd", 32'(strokes_done), 32'd0);
        seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (done) seen++;
        end
        chk("held_second_done_count", 32'(seen), 32'd1);
        chk("held_final_ready", 32'(cmd_ready), 32'd1);

        // Reset asserted mid-pump: immediate seal, no done afterwards.
        @(negedge clk);
        cmd_valid     = 1'b1;
        cmd_strokes   = SW'(3);
        cmd_phase_len = PW'(4);
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        for (int t = 1; t <= 10; t++) begin
            @(negedge clk);
            check_cycle(3, 4, 0, t);
            @(posedge clk);
            #1;
        end
        #1;
        rst_n = 1'b0;
        #1;
        check_reset_values("async_reset");
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        repeat (100) begin
            @(negedge clk);
            if (done) seen++;
        end
        chk("no_done_after_reset", 32'(seen), 32'd0);
        check_reset_values("after_reset");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
